// File: rtl/logic_unit_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_arbiter_pkg
// Brief  : Op encodings and result-slot state type shared by the logic unit
//          arbiter and its round-robin sub-block.
// Rev    : 1.0  initial release
// ============================================================================
package logic_unit_arbiter_pkg;

    // Bitwise operation encodings carried on req_op
    localparam logic [1:0] LOP_AND = 2'b00;
    localparam logic [1:0] LOP_OR  = 2'b01;
    localparam logic [1:0] LOP_XOR = 2'b10;
    localparam logic [1:0] LOP_NOR = 2'b11;

    // Result slot occupancy; FULL means rsp_valid is asserted
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_t;

endpackage : logic_unit_arbiter_pkg
`default_nettype wire

// File: rtl/logic_unit_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin grant. Searches from ptr upward with
//          wrap and grants the first pending request when enabled.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int ID_W = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic            enable,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] index,
    output logic            any_grant
);

    localparam logic [ID_W:0] c_nreq = (ID_W+1)'(NREQ);

    logic [ID_W:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo NREQ; first pending one wins
    always_comb begin
        grant     = '0;
        index     = '0;
        any_grant = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (w_cand >= c_nreq) begin
                w_cand = w_cand - c_nreq;
            end
            if (enable && !any_grant && req[w_cand[ID_W-1:0]]) begin
                grant[w_cand[ID_W-1:0]] = 1'b1;
                index                   = w_cand[ID_W-1:0];
                any_grant               = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module : logic_unit_arbiter
// Brief  : One shared AND/OR/XOR/NOR unit arbitrated round-robin between
//          NREQ requesters, with a single registered result slot that
//          supports backpressure and same-cycle drain + refill.
// Rev    : 1.0  initial release
// ============================================================================
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREQ  = 2,
    parameter int ID_W  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [2*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    output logic [WIDTH-1:0]      rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    input  logic                  rsp_ready
);

    localparam logic [ID_W:0] c_nreq = (ID_W+1)'(NREQ);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [WIDTH-1:0] r_data;
    logic [ID_W-1:0]  r_id;

    logic             w_slot_free;
    logic             w_enable;
    logic             w_accept;
    logic [ID_W-1:0]  w_idx;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_result;
    logic [ID_W:0]    w_ptr_inc;
    logic [ID_W-1:0]  w_ptr_nxt;

    assign rsp_valid   = (r_state == ST_FULL);
    assign rsp_data    = r_data;
    assign rsp_id      = r_id;
    assign w_slot_free = !rsp_valid || rsp_ready;
    // No grants may be visible while reset is held
    assign w_enable    = w_slot_free && !rst;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_arb (
        .req       (req_valid),
        .enable    (w_enable),
        .ptr       (r_ptr),
        .grant     (req_ready),
        .index     (w_idx),
        .any_grant (w_accept)
    );

    // Route the granted requester's op and operands to the shared unit
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_op = req_op[2*i +: 2];
                w_a  = req_a[WIDTH*i +: WIDTH];
                w_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Shared bitwise logic unit
    always_comb begin
        w_result = '0;
        case (w_op)
            LOP_AND: w_result = w_a & w_b;
            LOP_OR:  w_result = w_a | w_b;
            LOP_XOR: w_result = w_a ^ w_b;
            LOP_NOR: w_result = ~(w_a | w_b);
            default: w_result = '0;
        endcase
    end

    // Pointer moves just past the winner so it gets lowest priority next
    always_comb begin
        w_ptr_inc = {1'b0, w_idx} + (ID_W+1)'(1);
        w_ptr_nxt = w_ptr_inc[ID_W-1:0];
        if (w_ptr_inc >= c_nreq) begin
            w_ptr_nxt = '0;
        end
    end

    // Slot occupancy: fill on accept, empty on drain without refill
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
            ST_FULL:  if (!w_accept && rsp_ready) w_state_nxt = ST_EMPTY;
            default:  w_state_nxt = ST_EMPTY;
        endcase
    end

    // Slot state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result, id and round-robin pointer update only on an accepted request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_id   <= '0;
            r_ptr  <= '0;
        end else if (w_accept) begin
            r_data <= w_result;
            r_id   <= w_idx;
            r_ptr  <= w_ptr_nxt;
        end
    end

endmodule : logic_unit_arbiter
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_logic_unit_arbiter
// Brief  : Directed self-checking bench for logic_unit_arbiter (2 and 4
//          requester configurations).
// Rev    : 1.0  initial release
// ============================================================================
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    // Two-requester instance
    logic [1:0]  req_valid;
    logic [3:0]  req_op;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_ready;

    // Four-requester instance
    logic [3:0]   v4;
    logic [7:0]   op4;
    logic [127:0] a4;
    logic [127:0] b4;
    logic [3:0]   rdy4;
    logic         rv4;
    logic [31:0]  rd4;
    logic [1:0]   id4;
    logic         rr4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(32), .NREQ(2), .ID_W(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .rsp_ready(rsp_ready)
    );

    logic_unit_arbiter #(.WIDTH(32), .NREQ(4), .ID_W(2)) dut4 (
        .clk(clk), .rst(rst), .req_valid(v4), .req_op(op4),
        .req_a(a4), .req_b(b4), .req_ready(rdy4),
        .rsp_valid(rv4), .rsp_data(rd4), .rsp_id(id4),
        .rsp_ready(rr4)
    );

    typedef struct {
        int          who;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vecs[1] = '{1, 2'b11, 32'h00000000, 32'h00000000, 32'hFFFFFFFF};
        vecs[2] = '{0, 2'b01, 32'h00000000, 32'h00000000, 32'h00000000};
        vecs[3] = '{1, 2'b10, 32'h12345678, 32'h12345678, 32'h00000000};
        vecs[4] = '{0, 2'b01, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hFFFFFFFF};
        vecs[5] = '{1, 2'b10, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5};
        vecs[6] = '{0, 2'b11, 32'hF0F0F0F0, 32'h0F0F0000, 32'h00000F0F};

        // Reset state, with requests pending to show no grant under reset
        rst = 1'b1;
        req_valid = 2'b11; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        v4 = 4'b1111; op4 = '0; a4 = '0; b4 = '0; rr4 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset_rsp_data", rsp_data, 32'h0);
        chk("reset_rsp_id", 32'(rsp_id), 32'h0);
        chk("reset_req_ready", 32'(req_ready), 32'h0);
        chk("reset_req_ready4", 32'(rdy4), 32'h0);
        rst = 1'b0;
        req_valid = 2'b00;
        v4 = 4'b0000;

        // Single-requester op vectors; the idle slot carries decoy operands
        for (int i = 0; i < 7; i++) begin
            int w;
            w = vecs[i].who;
            req_valid = 2'b01 << w;
            req_op[2*w +: 2]       = vecs[i].op;
            req_a[32*w +: 32]      = vecs[i].a;
            req_b[32*w +: 32]      = vecs[i].b;
            req_op[2*(1-w) +: 2]   = ~vecs[i].op;
            req_a[32*(1-w) +: 32]  = ~vecs[i].a;
            req_b[32*(1-w) +: 32]  = vecs[i].b ^ 32'hDEADBEEF;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(2'b01 << w));
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(rsp_valid), 32'h1);
            chk($sformatf("vec%0d_data", i), rsp_data, vecs[i].exp);
            chk($sformatf("vec%0d_id", i), 32'(rsp_id), 32'(w));
        end

        // Backpressure: slot full, consumer stalled, both requesting
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        req_op = {2'b01, 2'b00};
        req_a  = {32'h11110000, 32'hFFFFFFFF};
        req_b  = {32'h00002222, 32'h0000FFFF};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_ready", 32'(req_ready), 32'h0);
            tick();
            chk("stall_valid", 32'(rsp_valid), 32'h1);
            chk("stall_data", rsp_data, 32'h00000F0F);
            chk("stall_id", 32'(rsp_id), 32'h0);
        end
        // Release: drain and accept in the same cycle, pointer favours req 1
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 32'(req_ready), 32'h2);
        tick();
        chk("release_valid", 32'(rsp_valid), 32'h1);
        chk("release_data", rsp_data, 32'h11112222);
        chk("release_id", 32'(rsp_id), 32'h1);
        req_valid = 2'b01;
        @(negedge clk);
        chk("follow_ready", 32'(req_ready), 32'h1);
        tick();
        chk("follow_data", rsp_data, 32'h0000FFFF);
        chk("follow_id", 32'(rsp_id), 32'h0);
        // Drain with no new request: valid drops, data held
        req_valid = 2'b00;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'h0);
        tick();
        chk("drain_valid", 32'(rsp_valid), 32'h0);
        chk("drain_data_held", rsp_data, 32'h0000FFFF);

        // Async reset while a result is held
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        tick();
        chk("pre_reset_valid", 32'(rsp_valid), 32'h1);
        req_valid = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(rsp_valid), 32'h0);
        chk("async_reset_data", rsp_data, 32'h0);
        chk("async_reset_ready", 32'(req_ready), 32'h0);
        tick();
        rst = 1'b0;

        // Continuous contention after reset: 0,1,0,1,... one result per cycle
        rsp_ready = 1'b1;
        req_op = {2'b00, 2'b10};
        req_a  = {32'h0000000F, 32'h00000001};
        req_b  = {32'h00000003, 32'h00000003};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("rr%0d_ready", k), 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            chk($sformatf("rr%0d_valid", k), 32'(rsp_valid), 32'h1);
            chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(k % 2));
            chk($sformatf("rr%0d_data", k), rsp_data, (k % 2 == 0) ? 32'h2 : 32'h3);
        end
        req_valid = 2'b00;

        // Four requesters: 1010 alternates 1,3; then 0001 gives 0
        v4 = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("n4_%0d_ready", k), 32'(rdy4), (k % 2 == 0) ? 32'h2 : 32'h8);
            tick();
            chk($sformatf("n4_%0d_id", k), 32'(id4), (k % 2 == 0) ? 32'h1 : 32'h3);
        end
        v4 = 4'b0001;
        @(negedge clk);
        chk("n4_single_ready", 32'(rdy4), 32'h1);
        tick();
        chk("n4_single_id", 32'(id4), 32'h0);
        // Idle cycles must not move the pointer (sits at 1)
        v4 = 4'b0000;
        tick();
        tick();
        chk("n4_idle_valid", 32'(rv4), 32'h0);
        v4 = 4'b0101;
        @(negedge clk);
        chk("n4_after_idle_ready", 32'(rdy4), 32'h4);
        tick();
        chk("n4_after_idle_id", 32'(id4), 32'h2);
        v4 = 4'b0000;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_logic_unit_arbiter
`default_nettype wire
